// File: rtl/fadd_seq_if.sv
// Request/grant/result bundle between requesters and the sequential FP adder.
interface fadd_seq_if;
    logic        req0;
    logic        req1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        busy;

    modport master (
        output req0, req1, a0, b0, a1, b1,
        input  gnt0, gnt1, done0, done1, result, flags, busy
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1,
        output gnt0, gnt1, done0, done1, result, flags, busy
    );
endinterface

// File: rtl/fadd_seq.sv
// Two-requester, multi-cycle single-precision magnitude adder
// (align by shifting, add, normalise by one bit, truncate).
module fadd_seq (
    input  logic      clk,
    input  logic      reset,
    fadd_seq_if.slave bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned EW = 8;
    localparam int unsigned MW = 24;
    localparam int unsigned CW = 5;
    localparam logic [EW-1:0] EXP_MAX = 8'hFF;
    localparam logic [CW-1:0] CNT_MAX = 5'd24;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          sign_q, sign_d;
    logic [EW-1:0] exp_x_q, exp_x_d;
    logic [MW-1:0] mant_x_q, mant_x_d;
    logic [MW-1:0] mant_y_q, mant_y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW:0]   sum_q, sum_d;
    logic [W-1:0]  result_q, result_d;
    logic [3:0]    flags_q, flags_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;

    logic          gnt0_c, gnt1_c;
    logic [W-1:0]  op_a_c, op_b_c;
    logic [EW-1:0] exp_a_c, exp_b_c, diff_c, exp_inc_c, exp_r_c;
    logic [MW-2:0] frac_r_c;
    logic          a_big_c;
    logic          unused_sign_b_c;

    // Round robin: on contention the requester not served last wins
    assign gnt0_c = (state_q == IDLE) && bus.req0 && (!bus.req1 || last_q);
    assign gnt1_c = (state_q == IDLE) && bus.req1 && (!bus.req0 || !last_q);

    assign op_a_c          = gnt1_c ? bus.a1 : bus.a0;
    assign op_b_c          = gnt1_c ? bus.b1 : bus.b0;
    assign unused_sign_b_c = op_b_c[W-1];
    assign exp_a_c         = op_a_c[W-2:MW-1];
    assign exp_b_c         = op_b_c[W-2:MW-1];
    assign a_big_c         = (exp_a_c >= exp_b_c);
    assign diff_c          = a_big_c ? (exp_a_c - exp_b_c) : (exp_b_c - exp_a_c);
    assign exp_inc_c       = (exp_x_q == EXP_MAX) ? EXP_MAX : (exp_x_q + EW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            sign_q   <= 1'b0;
            exp_x_q  <= '0;
            mant_x_q <= '0;
            mant_y_q <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            sign_q   <= sign_d;
            exp_x_q  <= exp_x_d;
            mant_x_q <= mant_x_d;
            mant_y_q <= mant_y_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        sign_d   = sign_q;
        exp_x_d  = exp_x_q;
        mant_x_d = mant_x_q;
        mant_y_d = mant_y_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        result_d = result_q;
        flags_d  = flags_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        exp_r_c  = exp_x_q;
        frac_r_c = sum_q[MW-2:0];

        case (state_q)
            IDLE: begin
                if (gnt0_c || gnt1_c) begin
                    state_d = ALIGN;
                    last_d  = gnt1_c;
                    sign_d  = op_a_c[W-1];
                    // Larger exponent becomes X; A wins a tie
                    if (a_big_c) begin
                        exp_x_d  = exp_a_c;
                        mant_x_d = {1'b1, op_a_c[MW-2:0]};
                        mant_y_d = {1'b1, op_b_c[MW-2:0]};
                    end else begin
                        exp_x_d  = exp_b_c;
                        mant_x_d = {1'b1, op_b_c[MW-2:0]};
                        mant_y_d = {1'b1, op_a_c[MW-2:0]};
                    end
                    cnt_d = (diff_c > EW'(CNT_MAX)) ? CNT_MAX : CW'(diff_c);
                end
            end
            ALIGN: begin
                if (cnt_q != '0) begin
                    mant_y_d = mant_y_q >> 1;
                    cnt_d    = cnt_q - CW'(1);
                end else begin
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d   = {1'b0, mant_x_q} + {1'b0, mant_y_q};
                state_d = NORM;
            end
            NORM: begin
                if (sum_q[MW]) begin
                    exp_r_c  = exp_inc_c;
                    frac_r_c = sum_q[MW-1:1];
                end
                result_d = {sign_q, exp_r_c, frac_r_c};
                flags_d  = {sign_q, ({exp_r_c, frac_r_c} == '0), sum_q[MW], (exp_r_c == EXP_MAX)};
                done0_d  = !last_q;
                done1_d  = last_q;
                state_d  = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt0   = gnt0_c;
    assign bus.gnt1   = gnt1_c;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.result = result_q;
    assign bus.flags  = flags_q;
    assign bus.busy   = (state_q != IDLE);
endmodule

// File: tb/tb_fadd_seq.sv
// Directed + random checks of fadd_seq against an arithmetic reference model.
module tb_fadd_seq;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    fadd_seq_if bus ();

    fadd_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Alignment distance the adder should use: |ea-eb| limited to 24
    function automatic int ref_shift(input logic [31:0] a, input logic [31:0] b);
        int d;
        d = int'(a[30:23]) - int'(b[30:23]);
        if (d < 0) d = -d;
        return (d > 24) ? 24 : d;
    endfunction

    // Returns {flags[3:0], result[31:0]}
    function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, mx, my, sum, frac;
        int              ex;
        bit              c;
        logic [31:0]     res;
        logic [7:0]      e8;
        logic [22:0]     f23;
        ma = 64'h800000 + longint'(a[22:0]);
        mb = 64'h800000 + longint'(b[22:0]);
        if (a[30:23] >= b[30:23]) begin
            ex = int'(a[30:23]); mx = ma; my = mb;
        end else begin
            ex = int'(b[30:23]); mx = mb; my = ma;
        end
        my  = my >> ref_shift(a, b);
        sum = mx + my;
        c   = (sum >= 64'h1000000);
        if (c) begin
            frac = (sum / 2) % 64'h800000;
            ex   = (ex + 1 > 255) ? 255 : ex + 1;
        end else begin
            frac = sum % 64'h800000;
        end
        e8  = 8'(ex);
        f23 = 23'(frac);
        res = {a[31], e8, f23};
        return {res[31], (res[30:0] == 31'd0), c, (ex == 255), res};
    endfunction

    // Wait for a grant, check arbitration and latency, then check completion
    task automatic serve(input int r, input logic [31:0] a, input logic [31:0] b,
                         input bit drop, input int exp_wait);
        int          w;
        int          k;
        logic [35:0] e;
        w = 0;
        k = 0;
        e = ref_add(a, b);
        #1;
        while (!(bus.gnt0 || bus.gnt1) && w < 60) begin
            @(negedge clk); #1; w++;
        end
        chk("grant_wait", 32'(w), 32'(exp_wait));
        chk("grant_sel", {30'd0, bus.gnt1, bus.gnt0}, (r == 1) ? 32'd2 : 32'd1);
        @(posedge clk);
        if (drop) begin
            #1;
            if (r == 1) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        end
        do begin
            @(posedge clk); k++; @(negedge clk);
        end while (!(bus.done0 || bus.done1) && k < 40);
        chk("done_latency", 32'(k), 32'(ref_shift(a, b) + 3));
        chk("done_sel", {30'd0, bus.done1, bus.done0}, (r == 1) ? 32'd2 : 32'd1);
        chk("result", bus.result, e[31:0]);
        chk("flags", {28'd0, bus.flags}, {28'd0, e[35:32]});
        chk("busy_done", {31'd0, bus.busy}, 32'd1);
        chk("gnt_while_busy", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    endtask

    task automatic drive(input int r, input logic [31:0] a, input logic [31:0] b);
        if (r == 1) begin
            bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b;
        end else begin
            bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b;
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          rr;
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        #3;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_flags", {28'd0, bus.flags}, 32'd0);
        chk("rst_done", {30'd0, bus.done1, bus.done0}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Directed corner cases
        @(negedge clk); drive(0, 32'h3F800000, 32'h3F800000);
        serve(0, 32'h3F800000, 32'h3F800000, 1'b1, 0);
        chk("dir_1p1", bus.result, 32'h40000000);
        chk("dir_1p1_flags", {28'd0, bus.flags}, 32'h2);
        @(negedge clk);
        chk("idle_after_done", {31'd0, bus.busy | bus.done0 | bus.done1}, 32'd0);
        drive(1, 32'h3F800000, 32'h40000000);
        serve(1, 32'h3F800000, 32'h40000000, 1'b1, 0);
        chk("dir_1p2", bus.result, 32'h40400000);
        @(negedge clk); drive(0, 32'h3F800000, 32'h30800000);
        serve(0, 32'h3F800000, 32'h30800000, 1'b1, 0);
        chk("dir_cap24", bus.result, 32'h3F800000);
        @(negedge clk); drive(0, 32'h7F7FFFFF, 32'h7F7FFFFF);
        serve(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 0);
        chk("dir_sat", bus.result, 32'h7FFFFFFF);
        chk("dir_sat_flags", {28'd0, bus.flags}, 32'h3);

        // Randomized single-requester operations
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb[30:23] = ra[30:23] - 8'($urandom_range(0, 6));
            rr = int'($urandom_range(0, 1));
            @(negedge clk); drive(rr, ra, rb);
            serve(rr, ra, rb, 1'b1, 0);
        end

        // Contention straight out of reset: req0 first, then strict alternation
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        drive(0, 32'h40A00000, 32'h3F000000);
        drive(1, 32'hC1200000, 32'h41200000);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) serve(0, 32'h40A00000, 32'h3F000000, 1'b0, (i == 0) ? 0 : 1);
            else            serve(1, 32'hC1200000, 32'h41200000, 1'b0, 1);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);

        // Reset in the middle of a long ALIGN phase
        drive(0, 32'h3F800000, 32'h30800000);
        #1;
        chk("abort_grant", {31'd0, bus.gnt0}, 32'd1);
        @(posedge clk); #1; bus.req0 = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_result", bus.result, 32'd0);
        chk("abort_flags", {28'd0, bus.flags}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done0 || bus.done1 || bus.busy) break;
        end
        chk("abort_no_done", {29'd0, bus.busy, bus.done1, bus.done0}, 32'd0);
        chk("abort_result_kept", bus.result, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fadd_seq.md
FADD_SEQ -- requirements
Module: fadd_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets immediately).
REQ-003 SHALL have ports req0, req1  input  1 each  requester add request; held high with operands stable until granted.
REQ-004 SHALL have ports a0, b0, a1, b1  input  32 each  IEEE-754 single operands A/B per requester.
REQ-005 SHALL have ports gnt0, gnt1  output  1 each  combinational grant; operands of granted requester latched at that clock edge.
REQ-006 SHALL have ports done0, done1  output  1 each  one-cycle completion pulse to the requester that was granted.
REQ-007 SHALL have port result  output  32  registered sum, held until next completion.
REQ-008 SHALL have port flags  output  4  registered {N,Z,C,V}, held until next completion.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, DONE; only IDLE accepts requests.
REQ-011 SHALL in IDLE assert at most one grant: single request -> grant it; both -> grant the requester not served last (round robin).
REQ-012 SHALL at the grant edge (E0) latch operands, record the served requester, and go to ALIGN; no grant means stay in IDLE.
REQ-013 SHALL at E0 take the operand with larger exponent as X (A on tie), the other as Y; mantissas are {1,frac[22:0]} (hidden 1 always, no denormal/Inf/NaN handling).
REQ-014 SHALL load an align count n = min(|expA-expB|, 24) at E0.
REQ-015 SHALL in ALIGN, while count>0, shift Y mantissa right 1 bit and decrement count per edge; at count==0 go to ADD (ALIGN lasts n+1 cycles).
REQ-016 SHALL in ADD compute 25-bit sum = mantX + mantY (magnitude addition only, no subtraction), then go to NORM.
REQ-017 SHALL in NORM: if sum[24]=1, fraction = sum[23:1] and exponent = expX+1; else fraction = sum[22:0], exponent = expX; truncate, no rounding.
REQ-018 SHALL at the NORM->DONE edge (E0+n+3) register result = {sign of original A, exponent, fraction} and flags.
REQ-019 SHALL set N = result[31], Z = (result[30:0]==0), C = sum[24], V = (result exponent == 8'hFF).
REQ-020 SHALL compute the exponent increment at 8 bits, saturating at 8'hFF (never wrapping to 0).
REQ-021 SHALL in DONE pulse done0 or done1 (the served requester) for exactly one cycle, then return to IDLE.
REQ-022 SHALL ignore requests arriving in non-IDLE states; they are served after return to IDLE, earliest grant one cycle after DONE.
REQ-023 SHALL keep gnt0/gnt1 low whenever busy=1.

Reset
REQ-024 SHALL on reset=0 force state IDLE, result=0, flags=0, done0=done1=0, align count=0, last-served=requester 1 (so req0 wins first tie).
REQ-025 SHALL abort any in-flight operation on reset with no done pulse and no result update.

Verification
REQ-026 SHALL cover req0, a0=0x3F800000, b0=0x3F800000 -> gnt0 at E0, done0 after edge E0+3, result 0x40000000, flags 0010.
REQ-027 SHALL cover req1, a1=0x3F800000, b1=0x40000000 -> n=1, done1 after edge E0+4, result 0x40400000, flags 0000.
REQ-028 SHALL cover a0=0x3F800000, b0=0x30800000 (diff 30) -> n capped 24, done0 after edge E0+27, result 0x3F800000.
REQ-029 SHALL cover a0=b0=0x7F7FFFFF -> result 0x7FFFFFFF, flags 0011 (C=1, V=1).
REQ-030 SHALL cover req0 and req1 both high from the first cycle after reset -> req0 served first, req1 granted in the IDLE cycle after done0, then alternation under continuous contention.
REQ-031 SHALL cover reset=0 asserted mid-ALIGN -> immediately IDLE, busy=0, no done pulse, result=0x00000000, flags=0000.
